// File: rtl/audio_sequencer_pkg.sv
// Shared types and constants for the audio sequencer slice.
// Imported by the interface, the priority picker and the sequencer top.
package audio_sequencer_pkg;

  typedef enum logic [1:0] {
    CLIP_CHOMP = 2'd0,
    CLIP_INTRO = 2'd1,
    CLIP_DEATH = 2'd2
  } clip_t;

  typedef enum logic {
    SEQ_IDLE = 1'b0,
    SEQ_PLAY = 1'b1
  } seq_state_t;

  localparam logic [7:0] SAMPLE_SILENCE = 8'h80;

  localparam int DEF_NUM_CLIPS = 3;
  localparam int DEF_ADDR_W    = 16;
  localparam int DEF_CLIP_W    = 2;

  // A clip needs at least two samples and must fit inside the ROM address space.
  function automatic logic clip_len_ok(input int len, input int addr_w);
    return (len >= 2) && (longint'(len) <= (longint'(1) << addr_w));
  endfunction

endpackage

// File: rtl/audio_sequencer_if.sv
// Request/ROM/PWM bundle of the audio sequencer; the slave modport is the sequencer.
// Defining AUDIO_VOLUME_EN adds the 4-bit volume input.
interface audio_sequencer_if #(
  parameter int NUM_CLIPS = 3,
  parameter int ADDR_W    = 16,
  parameter int CLIP_W    = 2
);

  logic                 sample_tick;
  logic [NUM_CLIPS-1:0] req;
  logic [NUM_CLIPS-1:0] loop;
  logic                 stop;
  logic [7:0]           rom_data;
`ifdef AUDIO_VOLUME_EN
  logic [3:0]           volume;
`endif
  logic [CLIP_W-1:0]    rom_sel;
  logic [ADDR_W-1:0]    rom_addr;
  logic [7:0]           sample_out;
  logic                 busy;
  logic [CLIP_W-1:0]    active_clip;
  logic                 done;

`ifdef AUDIO_VOLUME_EN
  modport master (
    output sample_tick, req, loop, stop, rom_data, volume,
    input  rom_sel, rom_addr, sample_out, busy, active_clip, done
  );
  modport slave (
    input  sample_tick, req, loop, stop, rom_data, volume,
    output rom_sel, rom_addr, sample_out, busy, active_clip, done
  );
`else
  modport master (
    output sample_tick, req, loop, stop, rom_data,
    input  rom_sel, rom_addr, sample_out, busy, active_clip, done
  );
  modport slave (
    input  sample_tick, req, loop, stop, rom_data,
    output rom_sel, rom_addr, sample_out, busy, active_clip, done
  );
`endif

endinterface

// File: rtl/audio_sequencer_prio_pick.sv
// Highest-set-index encoder over the pending request vector.
// The top uses it both to choose a clip from IDLE and to decide on preemption.
module audio_prio_pick
  import audio_sequencer_pkg::*;
#(
  parameter int N = DEF_NUM_CLIPS,
  parameter int W = DEF_CLIP_W
) (
  input  logic [N-1:0] vec,
  output logic         valid,
  output logic [W-1:0] idx
);

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      if (vec[i]) begin
        valid = 1'b1;
        idx   = W'(i);
      end
    end
  end

endmodule

// File: rtl/audio_sequencer.sv
// Clip sequencer: arbitrates play requests, walks the shared clip ROM on each
// sample strobe and hands samples to the pwm block. Optional macro: AUDIO_VOLUME_EN.
module audio_sequencer
  import audio_sequencer_pkg::*;
#(
  parameter int NUM_CLIPS           = DEF_NUM_CLIPS,
  parameter int ADDR_W              = DEF_ADDR_W,
  parameter int CLIP_W              = DEF_CLIP_W,
  parameter int CLIP_LEN[NUM_CLIPS] = '{5736, 12280, 33736}
) (
  input  logic             clk_25MHZ,
  input  logic             rst_n,
  audio_sequencer_if.slave bus
);

  for (genvar g = 0; g < NUM_CLIPS; g++) begin : g_len_check
    if (!clip_len_ok(CLIP_LEN[g], ADDR_W)) begin : g_bad_len
      $error("audio_sequencer: CLIP_LEN[%0d] must be within 2..2**ADDR_W", g);
    end
  end

  seq_state_t           state_q, state_d;
  logic [NUM_CLIPS-1:0] pending_q, pending_d;
  logic                 primed_q, primed_d;
  logic                 tick_hold_q, tick_hold_d;
  logic [CLIP_W-1:0]    rom_sel_q, rom_sel_d;
  logic [ADDR_W-1:0]    rom_addr_q, rom_addr_d;
  logic [CLIP_W-1:0]    active_clip_q, active_clip_d;
  logic [7:0]           sample_out_q, sample_out_d;
  logic                 done_q, done_d;

  logic [NUM_CLIPS-1:0] pend_eff;
  logic                 pick_valid;
  logic [CLIP_W-1:0]    pick_idx;
  logic [ADDR_W-1:0]    last_addr;
  logic                 loop_k;
  logic                 tick_eff;
  logic                 start;
  logic                 service;
  logic                 at_end;
  logic                 finish;
  logic                 start_taken;
  logic [7:0]           sample_val;

  assign pend_eff = pending_q | bus.req;
  assign tick_eff = bus.sample_tick | tick_hold_q;

  audio_prio_pick #(
    .N (NUM_CLIPS),
    .W (CLIP_W)
  ) u_pick (
    .vec   (pend_eff),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_comb begin
    last_addr = '0;
    loop_k    = 1'b0;
    for (int i = 0; i < NUM_CLIPS; i++) begin
      if (active_clip_q == CLIP_W'(i)) begin
        last_addr = ADDR_W'(CLIP_LEN[i] - 1);
        loop_k    = bus.loop[i];
      end
    end
  end

`ifdef AUDIO_VOLUME_EN
  logic signed [8:0] centered;
  logic signed [5:0] gain;

  // Scale around the silence midpoint; gain of 16 followed by >>>4 is an exact pass-through.
  always_comb begin
    centered   = $signed({1'b0, bus.rom_data}) - 9'sd128;
    gain       = $signed({2'b00, bus.volume}) + 6'sd1;
    sample_val = 8'((14'(centered) * 14'(gain)) >>> 4) + SAMPLE_SILENCE;
  end
`else
  assign sample_val = bus.rom_data;
`endif

  assign at_end  = (rom_addr_q == last_addr);
  assign start   = pick_valid && ((state_q == SEQ_IDLE) || (pick_idx >= active_clip_q));
  assign service = (state_q == SEQ_PLAY) && primed_q && tick_eff;
  assign finish  = service && at_end && !loop_k;

  // Precedence: stop, natural end of clip, start/preempt, then ordinary tick handling.
  always_comb begin
    state_d       = state_q;
    pending_d     = pend_eff;
    tick_hold_d   = tick_hold_q;
    rom_sel_d     = rom_sel_q;
    rom_addr_d    = rom_addr_q;
    active_clip_d = active_clip_q;
    sample_out_d  = sample_out_q;
    done_d        = 1'b0;
    start_taken   = 1'b0;

    if (bus.stop) begin
      state_d      = SEQ_IDLE;
      pending_d    = '0;
      tick_hold_d  = 1'b0;
      sample_out_d = SAMPLE_SILENCE;
    end else if (finish) begin
      sample_out_d = sample_val;
      done_d       = 1'b1;
      state_d      = SEQ_IDLE;
      tick_hold_d  = 1'b0;
    end else if (start) begin
      state_d       = SEQ_PLAY;
      rom_sel_d     = pick_idx;
      active_clip_d = pick_idx;
      rom_addr_d    = '0;
      pending_d     = pend_eff & ~(NUM_CLIPS'(1) << pick_idx);
      tick_hold_d   = tick_eff;
      start_taken   = 1'b1;
    end else if (state_q == SEQ_IDLE) begin
      tick_hold_d = 1'b0;
      if (bus.sample_tick) begin
        sample_out_d = SAMPLE_SILENCE;
      end
    end else if (service) begin
      sample_out_d = sample_val;
      tick_hold_d  = tick_hold_q & bus.sample_tick;
      rom_addr_d   = at_end ? '0 : rom_addr_q + 1'b1;
    end else if (tick_eff) begin
      tick_hold_d = 1'b1;
    end

    state_d  = state_d;
    primed_d = !start_taken && (rom_sel_d == rom_sel_q) && (rom_addr_d == rom_addr_q);
  end

  always_ff @(posedge clk_25MHZ or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= SEQ_IDLE;
      pending_q     <= '0;
      primed_q      <= 1'b0;
      tick_hold_q   <= 1'b0;
      rom_sel_q     <= '0;
      rom_addr_q    <= '0;
      active_clip_q <= '0;
      sample_out_q  <= SAMPLE_SILENCE;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      primed_q      <= primed_d;
      tick_hold_q   <= tick_hold_d;
      rom_sel_q     <= rom_sel_d;
      rom_addr_q    <= rom_addr_d;
      active_clip_q <= active_clip_d;
      sample_out_q  <= sample_out_d;
      done_q        <= done_d;
    end
  end

  assign bus.rom_sel     = rom_sel_q;
  assign bus.rom_addr    = rom_addr_q;
  assign bus.active_clip = active_clip_q;
  assign bus.sample_out  = sample_out_q;
  assign bus.done        = done_q;
  assign bus.busy        = (state_q == SEQ_PLAY);

endmodule
